// File: rtl/input_conditioner.sv
// Button front end: 2-flop synchronizer, integrating debounce, press pulses, pause and
// per-player direction masking. Define PAUSE_TOGGLE_EN for press-to-toggle pause.
module input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] btn_raw,
   output logic [4:0] btn_level,
   output logic [4:0] btn_press,
   output logic       pause,
   output logic       A_up,
   output logic       A_down,
   output logic       B_up,
   output logic       B_down
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [4:0]       sync1_q, sync1_d;
   logic [4:0]       sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q [5];
   logic [CNT_W-1:0] cnt_d [5];
   logic [4:0]       level_q, level_d;
   logic [4:0]       press_q, press_d;
   logic [3:0]       dir_q, dir_d;
   logic             pause_q, pause_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         press_q <= '0;
         dir_q   <= '0;
         pause_q <= 1'b0;
         for (int i = 0; i < 5; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         dir_q   <= dir_d;
         pause_q <= pause_d;
         for (int i = 0; i < 5; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      for (int i = 0; i < 5; i++) begin
         cnt_d[i] = '0;
         // Count only while the synchronized pin disagrees; any agreement restarts it.
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               level_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      press_d = level_d & ~level_q;
      // Opposing directions held together cancel to no move.
      dir_d = {level_q[3] & ~level_q[2], level_q[2] & ~level_q[3],
               level_q[1] & ~level_q[0], level_q[0] & ~level_q[1]};
`ifdef PAUSE_TOGGLE_EN
      pause_d = pause_q ^ press_q[4];
`else
      pause_d = level_q[4];
`endif
   end

   assign btn_level = level_q;
   assign btn_press = press_q;
   assign pause     = pause_q;
   assign A_up      = dir_q[3];
   assign A_down    = dir_q[2];
   assign B_up      = dir_q[1];
   assign B_down    = dir_q[0];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: vector table, directed corner sequences, and random
// stimulus checked against a history-based reference model.
module tb_input_conditioner;

   localparam int unsigned DC = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] btn_raw = '0;
   logic [4:0] btn_level, btn_press;
   logic       pause, A_up, A_down, B_up, B_down;

   input_conditioner #(
      .DEBOUNCE_CYCLES(DC),
      .CNT_W          (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .pause    (pause),
      .A_up     (A_up),
      .A_down   (A_down),
      .B_up     (B_up),
      .B_down   (B_down)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [14:0] dut_vec;
   assign dut_vec = {btn_level, btn_press, pause, A_up, A_down, B_up, B_down};

   // Reference model: a pin's level flips once the last DC synchronized samples
   // (raw delayed two edges) all differ from it.
   logic [4:0] raw_hist [$];
   logic [4:0] m_level, m_press;
   logic [3:0] m_dir;
   logic       m_pause;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   function automatic logic [4:0] sync_back(input int back);
      int idx;
      idx = raw_hist.size() - 3 - back;
      return (idx >= 0) ? raw_hist[idx] : 5'b0;
   endfunction

   task automatic model_reset();
      raw_hist.delete();
      m_level = '0;
      m_press = '0;
      m_dir   = '0;
      m_pause = 1'b0;
   endtask

   task automatic model_clock(input logic [4:0] raw);
      logic [4:0] nl;
      logic [4:0] s;
      logic       flip;
      raw_hist.push_back(raw);
      if (raw_hist.size() > DC + 4) void'(raw_hist.pop_front());
      for (int i = 0; i < 5; i++) begin
         flip = 1'b1;
         for (int j = 0; j < int'(DC); j++) begin
            s = sync_back(j);
            if (s[i] == m_level[i]) flip = 1'b0;
         end
         nl[i] = flip ? ~m_level[i] : m_level[i];
      end
`ifdef PAUSE_TOGGLE_EN
      m_pause = m_pause ^ m_press[4];
`else
      m_pause = m_level[4];
`endif
      m_dir   = {m_level[3] && !m_level[2], m_level[2] && !m_level[3],
                 m_level[1] && !m_level[0], m_level[0] && !m_level[1]};
      m_press = nl & ~m_level;
      m_level = nl;
   endtask

   task automatic tick(input logic [4:0] raw);
      btn_raw = raw;
      @(posedge clk);
      model_clock(raw);
      #1;
      chk("model", 32'(dut_vec), 32'({m_level, m_press, m_pause, m_dir}));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'(dut_vec), 32'(0));
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [4:0] raw;
      int         hold;
      logic [4:0] level;
      logic [3:0] dir;
   } vec_t;

   vec_t tbl [11];

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] bounce [4];
      logic       seen, prev;
      logic       e_r10, e_r11, e_f10, e_f11, e_f20;
      logic       r10, r11, f10, f11, f20;
      int         falls, fall_t, t4, t3;
      logic [31:0] v;
      int          hold;

      tbl[0]  = '{5'b00011, 12, 5'b00011, 4'b0000};
      tbl[1]  = '{5'b00010, 12, 5'b00010, 4'b0010};
      tbl[2]  = '{5'b00100,  5, 5'b00010, 4'b0010};
      tbl[3]  = '{5'b00010, 12, 5'b00010, 4'b0010};
      tbl[4]  = '{5'b01100, 12, 5'b01100, 4'b0000};
      tbl[5]  = '{5'b01000, 12, 5'b01000, 4'b1000};
      tbl[6]  = '{5'b00000, 12, 5'b00000, 4'b0000};
      tbl[7]  = '{5'b00001, 12, 5'b00001, 4'b0001};
      tbl[8]  = '{5'b00101, 12, 5'b00101, 4'b0101};
      tbl[9]  = '{5'b00000,  9, 5'b00101, 4'b0101};
      tbl[10] = '{5'b00000,  3, 5'b00000, 4'b0000};

      // Clean press on A_up: exact latency, one-cycle pulse, direction one cycle later.
      do_reset();
      for (int t = 1; t <= 11; t++) begin
         tick(5'b01000);
         if (t == 9) chk("a_up_level_early", 32'(btn_level), 32'(0));
         if (t == 10) begin
            chk("a_up_level", 32'(btn_level), 32'(5'b01000));
            chk("a_up_press", 32'(btn_press), 32'(5'b01000));
            chk("a_up_dir_early", 32'({A_up, A_down, B_up, B_down}), 32'(0));
         end
         if (t == 11) begin
            chk("a_up_press_end", 32'(btn_press), 32'(0));
            chk("a_up_dir", 32'({A_up, A_down, B_up, B_down}), 32'(4'b1000));
            chk("a_up_pause", 32'(pause), 32'(0));
         end
      end

      // Short glitches never get through.
      do_reset();
      seen = 1'b0;
      for (int r = 0; r < 3; r++) begin
         repeat (5) begin
            tick(5'b00100);
            seen = seen | btn_level[2] | btn_press[2] | A_down;
         end
         repeat (5) begin
            tick(5'b00000);
            seen = seen | btn_level[2] | btn_press[2] | A_down;
         end
      end
      chk("glitch_reject", 32'(seen), 32'(0));

      // Both B directions held cancel; releasing one lets the other through.
      repeat (12) tick(5'b00011);
      chk("b_both_level", 32'(btn_level[1:0]), 32'(2'b11));
      chk("b_both_dir", 32'({B_up, B_down}), 32'(0));
      for (int t = 1; t <= 11; t++) begin
         tick(5'b00010);
         if (t == 10) chk("b_up_early", 32'(B_up), 32'(0));
         if (t == 11) chk("b_up", 32'(B_up), 32'(1));
      end

      // Vector table.
      do_reset();
      for (int k = 0; k < 11; k++) begin
         repeat (tbl[k].hold) tick(tbl[k].raw);
         chk($sformatf("tbl%0d_level", k), 32'(btn_level), 32'(tbl[k].level));
         chk($sformatf("tbl%0d_dir", k), 32'({A_up, A_down, B_up, B_down}), 32'(tbl[k].dir));
      end

      // Pause behaviour over two clean presses.
      do_reset();
      for (int p = 0; p < 2; p++) begin
         r10 = 0; r11 = 0; f10 = 0; f11 = 0; f20 = 0;
         for (int t = 1; t <= 20; t++) begin
            tick(5'b10000);
            if (t == 10) r10 = pause;
            if (t == 11) r11 = pause;
         end
         for (int t = 1; t <= 20; t++) begin
            tick(5'b00000);
            if (t == 10) f10 = pause;
            if (t == 11) f11 = pause;
            if (t == 20) f20 = pause;
         end
`ifdef PAUSE_TOGGLE_EN
         e_r10 = (p == 1); e_r11 = (p == 0);
         e_f10 = (p == 0); e_f11 = (p == 0); e_f20 = (p == 0);
`else
         e_r10 = 1'b0; e_r11 = 1'b1; e_f10 = 1'b1; e_f11 = 1'b0; e_f20 = 1'b0;
`endif
         chk($sformatf("pause%0d_r10", p), 32'(r10), 32'(e_r10));
         chk($sformatf("pause%0d_r11", p), 32'(r11), 32'(e_r11));
         chk($sformatf("pause%0d_f10", p), 32'(f10), 32'(e_f10));
         chk($sformatf("pause%0d_f11", p), 32'(f11), 32'(e_f11));
         chk($sformatf("pause%0d_f20", p), 32'(f20), 32'(e_f20));
      end

      // Bouncing release on A_up.
      do_reset();
      repeat (12) tick(5'b01000);
      bounce[0] = 5'b00000; bounce[1] = 5'b01000; bounce[2] = 5'b00000; bounce[3] = 5'b01000;
      falls = 0; fall_t = -1; seen = 1'b0; prev = btn_level[3];
      for (int b = 0; b < 4; b++) begin
         tick(bounce[b]);
         if (prev && !btn_level[3]) falls++;
         seen = seen | btn_press[3];
         prev = btn_level[3];
      end
      for (int t = 1; t <= 15; t++) begin
         tick(5'b00000);
         if (prev && !btn_level[3]) begin
            falls++;
            fall_t = t;
         end
         seen = seen | btn_press[3];
         prev = btn_level[3];
      end
      chk("bounce_falls", 32'(falls), 32'(1));
      chk("bounce_fall_t", 32'(fall_t), 32'(10));
      chk("bounce_no_press", 32'(seen), 32'(0));

      // Reset in the middle of a pending pause press.
      do_reset();
      repeat (12) tick(5'b01000);
      repeat (7) tick(5'b11000);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset", 32'(dut_vec), 32'(0));
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      t4 = 0; t3 = 0;
      for (int t = 1; t <= 12; t++) begin
         tick(5'b11000);
         if (btn_press[4] && t4 == 0) t4 = t;
         if (btn_press[3] && t3 == 0) t3 = t;
      end
      chk("post_reset_press4_t", 32'(t4), 32'(10));
      chk("post_reset_press3_t", 32'(t3), 32'(10));

      // Random stimulus against the model, with occasional asynchronous resets.
      do_reset();
      for (int s = 0; s < 300; s++) begin
         v = $urandom;
         hold = $urandom_range(1, 14);
         for (int h = 0; h < hold; h++) tick(v[4:0]);
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage between the raw board button pins (pause, player A up/down, player B up/down) and the game logic (enable generator pause input, collision controller paddle-move inputs).
- Each channel passes through a 2-flop synchronizer and an integrating debounce counter.
- Produces clean levels, one-cycle press pulses, a latched pause state, and opposing-direction masking per player.
- Runs on the PLL output clock; all outputs are registered.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive clk cycles a synchronized input must disagree with the stable state before the stable state flips (~10 ms at 25 MHz); legal range 2..2^20.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock (PLL global output)
- rst_n  in  1  asynchronous active-low reset
- btn_raw  in  5  raw pins, active-high: [4] pause, [3] A_up, [2] A_down, [1] B_up, [0] B_down
- btn_level  out  5  debounced stable level per channel, same bit order
- btn_press  out  5  one-cycle pulse on each debounced 0->1 transition
- pause  out  1  game paused flag
- A_up  out  1  player A move up (debounced, conflict-masked)
- A_down  out  1  player A move down
- B_up  out  1  player B move up
- B_down  out  1  player B move down

Behaviour:
- Reset (rst_n low, async assert): all synchronizer flops, counters, btn_level, btn_press, pause and direction outputs go to 0 immediately.
- Release is sampled on the next clk edge.
- Synchronizer: btn_raw passes through two flops per bit; sync value = second flop.
- Debounce, per channel, two states STABLE0 / STABLE1 held in btn_level[i]:
  - If sync == btn_level[i], the counter clears to 0.
  - If sync != btn_level[i] and counter == DEBOUNCE_CYCLES-1, then btn_level[i] <= sync and the counter clears.
  - Otherwise, if sync != btn_level[i], the counter increments.
- Any glitch shorter than DEBOUNCE_CYCLES (sync returning to btn_level) restarts the count from 0.
- Latency: a clean raw edge appears on btn_level exactly 2 + DEBOUNCE_CYCLES clk edges later.
- Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1.
- btn_press[i]: registered; high for exactly the one cycle in which btn_level[i] transitions 0->1; low otherwise, including on release.
- Direction outputs, registered one cycle after btn_level:
  - A_up = btn_level[3] & ~btn_level[2]; A_down = btn_level[2] & ~btn_level[3].
  - Same for B with bits [1]/[0].
  - Both held means both outputs 0 (no move).
- Pause: see Optional Feature. pause is registered, 1 cycle after the btn_press / btn_level event.
- Simultaneous events across channels are fully independent; channels share no state.
- Reset mid-count discards the partial count; post-reset stable state is 0 regardless of the pin level.
- A pin held high through reset therefore produces a press after 2 + DEBOUNCE_CYCLES cycles.

Optional Feature:
- Macro: PAUSE_TOGGLE_EN.
- Defined: pause toggles on each btn_press[4] (press-to-pause, press-to-resume); release has no effect.
- Not defined: pause = btn_level[4] registered (hold-to-pause).
- btn_level / btn_press behaviour is identical in both builds.

Test Plan (bench uses DEBOUNCE_CYCLES=8):
- Reset then raw[3]=1 held → btn_level[3] rises on edge 10 after the change; btn_press[3] high 1 cycle; A_up=1 one cycle later; other outputs stay 0.
- raw[2] pulsed high for 5 cycles, then low, repeated 3 times → btn_level[2], btn_press[2] and A_down never assert.
- raw[1] and raw[0] both held high → btn_level[1:0]=2'b11; B_up=0 and B_down=0; release raw[0] → B_up=1 after 10+1 cycles.
- PAUSE_TOGGLE_EN defined: two clean presses of raw[4] (each 20 cycles high, 20 low) → pause 0→1 after the first press, 1→0 after the second; undefined build → pause follows the held level with 11-cycle lag.
- Bouncing release on raw[3] (1,0,1,0 alternating each cycle, then stable 0) → btn_level[3] falls exactly once, 10 cycles after the last bounce; no btn_press pulse.
- rst_n asserted at count 5 of a pending raw[4] press → all outputs 0 asynchronously; after release with raw[4] still high, press occurs 10 cycles later.
